bus_follower_regfile: RTL and testbench
=======================================

// Module: bus_follower_regfile
// PURPOSE
// - Follower (responder) end of the bus_if valid/ready protocol: a small register file that completes
//   master write_data/read_data transfers with programmable wait states.
// - Sits behind the follower side of bus_if as the default target for bring-up.
// - Also serves as the bench target for master-side blocks.
// - Explicit ports carry the read-return path, because the follower modport has data as input only.
// PARAMETERS
// - DATA_W       8       data width; matches test_pkg::data_t
// - ADDR_W       32      address width; matches bus_if ADDR_WIDTH
// - DEPTH        16      number of DATA_W registers; word addressed
// - BASE_ADDR    0       first decoded address
// - WAIT_CYCLES  1       wait states inserted before ready; 0..15
// PORTS
// - clk           in   1       clock, rising edge
// - rst           in   1       reset, asynchronous, active-high
// - valid         in   1       master request; held until completion
// - addr          in   ADDR_W  transfer address
// - wdata         in   DATA_W  write data
// - write_enable  in   1       1 = write, 0 = read
// - ready         out  1       follower acknowledge; registered, one-cycle pulse
// - rdata         out  DATA_W  read data; valid while ready=1, 0 otherwise
// - err           out  1       decode error; valid while ready=1, 0 otherwise
// - xfer_count    out  16      completed transfers, including errored ones; wraps 0xFFFF->0
// BEHAVIOUR
// - Reset: ready=0, rdata=0, err=0, xfer_count=0, state=IDLE, all DEPTH registers=0. Async assert, sync release.
// - A transfer completes on a rising edge where valid=1 and ready=1. No other condition completes a transfer.
// - FSM states:
//   - IDLE: on an edge with valid=1 (edge E0), capture addr, wdata and write_enable.
//     Go to WAIT with cnt=WAIT_CYCLES-1, or to ACK if WAIT_CYCLES=0.
//   - WAIT: cnt decrements each edge. At cnt=0, go to ACK. If valid=0 at any edge, abort to IDLE.
//   - ACK: ready=1, rdata and err driven. The next edge always returns to IDLE.
//     - valid=1 at that edge: completion. Perform the write, increment xfer_count.
//     - valid=0 at that edge: abort. No write, no count.
// - Latency: ready is high in the cycle after edge E0+WAIT_CYCLES. Completion is at edge E0+WAIT_CYCLES+1.
//   Minimum 1 cycle at WAIT_CYCLES=0.
// - Captured values are used. Changes to addr, wdata or write_enable after E0 are ignored.
// - Decode: in range iff BASE_ADDR <= addr < BASE_ADDR+DEPTH. Index = addr-BASE_ADDR, using ADDR_W-bit arithmetic.
// - Out-of-range transfer: ready is still given with err=1. A write is dropped; a read returns rdata=0.
// - Read data: in ACK, rdata = reg[idx], the value before any write at the completion edge.
// - Back-to-back: after ACK the block is in IDLE for at least one edge.
//   valid held high re-captures at the first IDLE edge, so each transfer costs at least 2 cycles.
// - Async rst mid-transfer: ready drops immediately, the transfer is lost, registers clear.
// - WAIT_CYCLES > 15 is rejected by an elaboration-time $error.
// TESTING
// - rst pulse -> ready=0, rdata=0, err=0, xfer_count=0; reads of addrs BASE..BASE+15 return 0.
// - WAIT_CYCLES=2, write BASE+3 data 8'hA5 -> ready high for exactly one cycle, 3 cycles after E0; xfer_count=1.
// - Then read BASE+3 -> rdata=8'hA5 and err=0 while ready=1; xfer_count=2.
// - Write BASE+16 data 8'h5A -> err=1 with ready; a read of BASE+0..15 shows no change.
// - Read BASE+16 -> rdata=0, err=1.
// - Master drops valid while in WAIT -> ready never rises, target register unchanged, xfer_count unchanged.
// - Write BASE+7 then read BASE+7 via master tasks back-to-back at WAIT_CYCLES=0 -> read returns written value.
//   Each transfer completes 1 cycle after capture.
// - Assert rst while in WAIT after a write request -> ready=0 the same cycle, written register stays 0,
//   xfer_count=0; the next transfer after release works normally.

Source files
------------

// File: rtl/bus_follower_regfile.sv
// bus_follower_regfile
// Responder end of the valid/ready bus: a small word-addressed register file that completes
// read and write transfers after a programmable number of wait states.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   valid        in   master request, held until completion
//   addr         in   transfer address (ADDR_W)
//   wdata        in   write data (DATA_W)
//   write_enable in   1 = write, 0 = read
//   ready        out  one-cycle acknowledge pulse, decoded from the state register
//   rdata        out  read data while ready=1, else 0
//   err          out  decode error while ready=1, else 0
//   xfer_count   out  completed transfers (errored ones included), wraps at 16 bits
module bus_follower_regfile #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH       = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              write_enable,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [15:0]       xfer_count
);

  if (WAIT_CYCLES > 15) begin : gen_wait_check
    $error("bus_follower_regfile: WAIT_CYCLES must be in 0..15");
  end

  localparam int unsigned IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CntInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              capture;
  logic [15:0]       xfer_count_q;
  logic [DATA_W-1:0] regs_q [DEPTH];

  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic [IdxW-1:0]   idx;
  logic              complete;

  // Decode works on the captured address so later bus changes cannot affect the transfer.
  // The offset wraps below BASE_ADDR, so a single unsigned compare covers both bounds.
  always_comb begin
    offset   = addr_q - BASE_ADDR;
    in_range = (offset < ADDR_W'(DEPTH));
    idx      = offset[IdxW-1:0];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = StAck;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (!valid) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: rdata shows the pre-write contents during ACK.
  always_comb begin
    ready    = (state_q == StAck);
    complete = ready & valid;
    err      = ready & ~in_range;
    rdata    = (ready && in_range) ? regs_q[idx] : '0;
  end

  // Request capture and transfer counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      xfer_count_q <= 16'd0;
    end else begin
      if (capture) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        we_q    <= write_enable;
      end
      if (complete) begin
        xfer_count_q <= xfer_count_q + 16'd1;
      end
    end
  end

  // Register array; out-of-range writes are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else if (complete && we_q && in_range) begin
      regs_q[idx] <= wdata_q;
    end
  end

  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_bus_follower_regfile.sv
// Bench for bus_follower_regfile: two instances (2 wait states and 0 wait states) driven by
// directed and random transfers, checked against an array-based reference model.
module tb_bus_follower_regfile;

  localparam logic [31:0] Base  = 32'h0000_1000;
  localparam int          WaitA = 2;
  localparam int          WaitB = 0;

  logic        clk;
  logic        rst;
  logic        valid_a, valid_b;
  logic [31:0] addr;
  logic [7:0]  wdata;
  logic        we;

  logic        ready_a, ready_b, err_a, err_b;
  logic [7:0]  rdata_a, rdata_b;
  logic [15:0] cnt_a, cnt_b;

  int          chk_total = 0;
  int          chk_pass  = 0;

  // Reference model: register contents and completed-transfer counts per instance.
  logic [7:0]  model  [2][16];
  logic [15:0] mcount [2];

  bus_follower_regfile #(
    .DATA_W(8), .ADDR_W(32), .DEPTH(16), .BASE_ADDR(Base), .WAIT_CYCLES(WaitA)
  ) dut_a (
    .clk(clk), .rst(rst), .valid(valid_a), .addr(addr), .wdata(wdata),
    .write_enable(we), .ready(ready_a), .rdata(rdata_a), .err(err_a), .xfer_count(cnt_a)
  );

  bus_follower_regfile #(
    .DATA_W(8), .ADDR_W(32), .DEPTH(16), .BASE_ADDR(Base), .WAIT_CYCLES(WaitB)
  ) dut_b (
    .clk(clk), .rst(rst), .valid(valid_b), .addr(addr), .wdata(wdata),
    .write_enable(we), .ready(ready_b), .rdata(rdata_b), .err(err_b), .xfer_count(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "timeout");
  end

  function automatic logic rdy(input int d);
    return (d != 0) ? ready_b : ready_a;
  endfunction
  function automatic logic erro(input int d);
    return (d != 0) ? err_b : err_a;
  endfunction
  function automatic logic [7:0] rdat(input int d);
    return (d != 0) ? rdata_b : rdata_a;
  endfunction
  function automatic logic [15:0] cnt(input int d);
    return (d != 0) ? cnt_b : cnt_a;
  endfunction
  function automatic int wait_of(input int d);
    return (d != 0) ? WaitB : WaitA;
  endfunction

  task automatic set_valid(input int d, input logic v);
    if (d != 0) valid_b = v;
    else valid_a = v;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_total++;
    assert (obs === exp) begin
      chk_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      mcount[d] = 16'd0;
      for (int i = 0; i < 16; i++) model[d][i] = 8'h00;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    unique case ($urandom_range(0, 7))
      0:       return Base + 32'd16 + 32'($urandom_range(0, 7));
      1:       return Base - 32'd1 - 32'($urandom_range(0, 3));
      2:       return $urandom();
      default: return Base + 32'($urandom_range(0, 15));
    endcase
  endfunction

  // One transfer, starting and ending at a falling edge. With hold=1 valid stays high so the
  // next call re-captures at the first edge after completion.
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [7:0] wd,
                      input logic hold);
    logic [31:0] off;
    logic        inr;
    logic [7:0]  exp_rd;
    off    = a - Base;
    inr    = (off < 32'd16);
    exp_rd = inr ? model[d][off[3:0]] : 8'h00;
    addr   = a;
    wdata  = wd;
    we     = w;
    set_valid(d, 1'b1);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < wait_of(d); k++) begin
      check("ready_early", 32'(rdy(d)), 32'd0);
      @(negedge clk);
    end
    check("ready_latency", 32'(rdy(d)), 32'd1);
    check("err", 32'(erro(d)), 32'(!inr));
    if (!w) check("rdata", 32'(rdat(d)), 32'(exp_rd));
    @(posedge clk);
    if (w && inr) model[d][off[3:0]] = wd;
    mcount[d] = mcount[d] + 16'd1;
    @(negedge clk);
    if (!hold) set_valid(d, 1'b0);
    check("ready_pulse", 32'(rdy(d)), 32'd0);
    check("xfer_count", 32'(cnt(d)), 32'(mcount[d]));
  endtask

  initial begin
    rst     = 1'b1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    addr    = '0;
    wdata   = '0;
    we      = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(rdy(d)), 32'd0);
      check("rst_rdata", 32'(rdat(d)), 32'd0);
      check("rst_err", 32'(erro(d)), 32'd0);
      check("rst_count", 32'(cnt(d)), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Every register reads zero after reset.
    for (int i = 0; i < 16; i++) xfer(0, 1'b0, Base + 32'(i), 8'h00, i != 15);

    // Write then read back with two wait states.
    xfer(0, 1'b1, Base + 32'd3, 8'hA5, 1'b0);
    xfer(0, 1'b0, Base + 32'd3, 8'h00, 1'b0);

    // Out-of-range write is dropped, out-of-range read returns zero.
    xfer(0, 1'b1, Base + 32'd16, 8'h5A, 1'b0);
    for (int i = 0; i < 16; i++) xfer(0, 1'b0, Base + 32'(i), 8'h00, i != 15);
    xfer(0, 1'b0, Base + 32'd16, 8'h00, 1'b0);

    // Master withdraws valid during the wait states.
    addr    = Base + 32'd3;
    wdata   = 8'h77;
    we      = 1'b1;
    valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("abort_ready", 32'(ready_a), 32'd0);
      @(negedge clk);
    end
    check("abort_count", 32'(cnt_a), 32'(mcount[0]));
    xfer(0, 1'b0, Base + 32'd3, 8'h00, 1'b0);

    // Back-to-back write/read with no wait states.
    xfer(1, 1'b1, Base + 32'd7, 8'hC3, 1'b1);
    xfer(1, 1'b0, Base + 32'd7, 8'h00, 1'b0);

    // Randomized bursts against the model.
    for (int b = 0; b < 20; b++) begin
      int d;
      int n;
      d = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 3));
      for (int j = 0; j < n; j++) begin
        xfer(d, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom()), j != n - 1);
      end
    end

    // Reset during wait states of a write.
    addr    = Base + 32'd9;
    wdata   = 8'h3C;
    we      = 1'b1;
    valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstwait_ready", 32'(ready_a), 32'd0);
    check("rstwait_count_a", 32'(cnt_a), 32'd0);
    check("rstwait_count_b", 32'(cnt_b), 32'd0);
    valid_a = 1'b0;
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    xfer(0, 1'b0, Base + 32'd9, 8'h00, 1'b0);
    xfer(0, 1'b1, Base + 32'd9, 8'h96, 1'b1);
    xfer(0, 1'b0, Base + 32'd9, 8'h00, 1'b0);

    // Reset while acknowledging drops ready at once and loses the write.
    addr    = Base + 32'd2;
    wdata   = 8'hE1;
    we      = 1'b1;
    valid_a = 1'b1;
    @(posedge clk);
    repeat (WaitA + 1) @(negedge clk);
    check("ack_before_rst", 32'(ready_a), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstack_ready", 32'(ready_a), 32'd0);
    check("rstack_count", 32'(cnt_a), 32'd0);
    valid_a = 1'b0;
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    xfer(0, 1'b0, Base + 32'd2, 8'h00, 1'b0);
    xfer(0, 1'b0, Base + 32'd9, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
